// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers.
// State enum, weight field type, pointer width and weight floor.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_WW = 16;

  typedef logic [MAX_WW-1:0] wfield_t;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // A zero weight still buys one transfer.
  function automatic wfield_t eff_weight(input wfield_t w);
    return (w == '0) ? wfield_t'(1) : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set (req & ~excl) scanning ptr+1..ptr+N mod N.
// Ports: req, ptr, excl in; found, idx out. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  // Scan from the far end so the nearest candidate wins last.
  always_comb begin
    int j;
    logic [PW-1:0] ji;
    j     = 0;
    ji    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(ptr) + k) % N;
      ji = PW'(j);
      if (cand[ji]) begin
        found = 1'b1;
        idx   = ji;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with held grant, ack handshake and credit.
// Ports: clk, rst_n, req[N], weight[N*WW], ack -> grant, grant_valid, grant_idx, credit. Macro WRR_ASSERT_EN adds checks.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int WW = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N*WW-1:0] weight,
  input  logic          ack,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx,
  output logic [WW-1:0] credit
);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] credit_q, credit_d;

  logic [WW-1:0] w_f [N];
  logic [N-1:0]  cur_oh;
  logic [N-1:0]  excl;
  logic [PW-1:0] scan_ptr;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] load_idx;
  logic [WW-1:0] fresh;
  logic          pick_found;
  logic          cur_req;
  logic          exhausted;
  logic          burst_end;
  logic          busy;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_f[g] = weight[g*WW +: WW];
  end

  assign busy      = (state_q == BUSY);
  assign cur_oh    = N'(1) << idx_q;
  assign cur_req   = req[idx_q];
  assign exhausted = ack && (credit_q == WW'(1));
  assign burst_end = busy && (!cur_req || exhausted);
  assign scan_ptr  = busy ? idx_q : ptr_q;
  assign excl      = (busy && exhausted) ? cur_oh : '0;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (scan_ptr),
    .excl  (excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Fallback load target is the sole remaining requester itself.
  assign load_idx = pick_found ? pick_idx : idx_q;
  assign fresh    = WW'(eff_weight(wfield_t'(w_f[load_idx])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ptr_q    <= PW'(N-1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BUSY;
          idx_d    = pick_idx;
          credit_d = fresh;
        end
      end
      BUSY: begin
        if (burst_end) begin
          ptr_d = idx_q;
          if (pick_found || cur_req) begin
            idx_d    = load_idx;
            credit_d = fresh;
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            credit_d = '0;
          end
        end else if (ack && credit_q > WW'(1)) begin
          credit_d = credit_q - WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_valid = busy;
    grant       = busy ? cur_oh : '0;
    grant_idx   = busy ? idx_q : '0;
    credit      = credit_q;
  end

`ifdef WRR_ASSERT_EN
  localparam int SCW = WW + PW + 2;

  logic [SCW-1:0] starve_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) starve_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || grant[i])
          starve_q[i] <= '0;
        else if (ack && grant_valid)
          starve_q[i] <= starve_q[i] + SCW'(1);
      end
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_valid: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid == |grant);
  a_idx: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> grant[grant_idx]);
  a_newreq: assert property (@(posedge clk) disable iff (!rst_n)
    ((grant & ~$past(grant) & ~$past(req)) == '0));
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> credit != '0);

  for (genvar g = 0; g < N; g++) begin : g_starve
    a_starve: assert property (@(posedge clk) disable iff (!rst_n)
      starve_q[g] < SCW'((N-1) << WW));
  end
`endif

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter.
// Directed vector table, async-reset sequence, randomized model compare.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] weight = 16'h1111;
  logic        ack = 1'b0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [3:0]  credit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .credit      (credit)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        ack;
    logic [15:0] w;
    logic [3:0]  eg;
    logic [3:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic a,
                              logic [15:0] w, logic [3:0] eg,
                              logic [3:0] ec);
    vec_t v;
    v.rst_n = r; v.req = q; v.ack = a;
    v.w = w; v.eg = eg; v.ec = ec;
    return v;
  endfunction

  function automatic logic [1:0] oh2i(logic [3:0] oh);
    for (int i = 0; i < 4; i++)
      if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic check(string name, logic [10:0] exp);
    logic [10:0] got;
    got = {grant, grant_valid, grant_idx, credit};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got g=%b v=%b i=%0d c=%0d want g=%b v=%b i=%0d c=%0d",
        name, got[10:7], got[6], got[5:4], got[3:0],
        exp[10:7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  function automatic logic [10:0] pack_exp(logic [3:0] g, logic [3:0] c);
    return {g, |g, oh2i(g), c};
  endfunction

  // Reference model: current holder, transfers left, last holder.
  int m_cur, m_left, m_last;

  function automatic int eff(logic [15:0] w, int i);
    int v;
    v = int'((w >> (4*i)) & 16'hF);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int scan(logic [3:0] r, int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_left = 0; m_last = 3;
  endtask

  task automatic model_step(logic [3:0] r, logic a, logic [15:0] w);
    if (m_cur < 0) begin
      m_cur = scan(r, m_last);
      m_left = (m_cur < 0) ? 0 : eff(w, m_cur);
    end else if (!r[m_cur] || (a && m_left == 1)) begin
      // Scan wraps back to the holder last: covers lone re-grant.
      m_last = m_cur;
      m_cur = scan(r, m_last);
      m_left = (m_cur < 0) ? 0 : eff(w, m_cur);
    end else if (a) begin
      m_left = m_left - 1;
    end
  endtask

  function automatic logic [10:0] model_exp();
    if (m_cur < 0) return 11'd0;
    return {4'(1 << m_cur), 1'b1, 2'(m_cur), 4'(m_left)};
  endfunction

  initial begin
    // Rotation with unit weights.
    vecs.push_back(mk(0, 4'hF, 0, 16'h1111, 4'b0000, 0));
    vecs.push_back(mk(1, 4'hF, 0, 16'h1111, 4'b0001, 1));
    vecs.push_back(mk(1, 4'hF, 1, 16'h1111, 4'b0010, 1));
    vecs.push_back(mk(1, 4'hF, 1, 16'h1111, 4'b0100, 1));
    vecs.push_back(mk(1, 4'hF, 1, 16'h1111, 4'b1000, 1));
    vecs.push_back(mk(1, 4'hF, 1, 16'h1111, 4'b0001, 1));
    // w0=3, w2=2, req 0101, ack held high.
    vecs.push_back(mk(0, 4'h5, 1, 16'h1213, 4'b0000, 0));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 3));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 2));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 1));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0100, 2));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0100, 1));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 3));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 2));
    vecs.push_back(mk(1, 4'h5, 1, 16'h1213, 4'b0001, 1));
    // w0=0, w1=2, w2=0, w3=1: stall, lone reload, withdrawal.
    vecs.push_back(mk(0, 4'h2, 0, 16'h1020, 4'b0000, 0));
    vecs.push_back(mk(1, 4'h2, 0, 16'h1020, 4'b0010, 2));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 4'h2, 0, 16'h1020, 4'b0010, 2));
    vecs.push_back(mk(1, 4'h2, 1, 16'h1020, 4'b0010, 1));
    vecs.push_back(mk(1, 4'h2, 1, 16'h1020, 4'b0010, 2));
    vecs.push_back(mk(1, 4'h2, 1, 16'h1020, 4'b0010, 1));
    vecs.push_back(mk(1, 4'h6, 1, 16'h1020, 4'b0100, 1));
    vecs.push_back(mk(1, 4'hB, 0, 16'h1020, 4'b1000, 1));
    vecs.push_back(mk(1, 4'hB, 1, 16'h1020, 4'b0001, 1));
    vecs.push_back(mk(1, 4'h0, 0, 16'h1020, 4'b0000, 0));
    vecs.push_back(mk(1, 4'h0, 1, 16'h1020, 4'b0000, 0));
    vecs.push_back(mk(1, 4'h2, 1, 16'h1020, 4'b0010, 2));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n  = vecs[i].rst_n;
      req    = vecs[i].req;
      ack    = vecs[i].ack;
      weight = vecs[i].w;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), pack_exp(vecs[i].eg, vecs[i].ec));
    end

    // Async reset mid-burst drops the grant before any edge.
    rst_n = 1'b0;
    #2;
    check("async_rst", 11'd0);
    rst_n  = 1'b1;
    req    = 4'hF;
    ack    = 1'b0;
    weight = 16'h1111;
    @(posedge clk);
    #1;
    check("post_rst", pack_exp(4'b0001, 4'd1));

    // Randomized run against the model.
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) weight = 16'($urandom);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      ack = ($urandom_range(2) != 0);
      @(posedge clk);
      model_step(req, ack, weight);
      #1;
      check($sformatf("rand%0d", c), model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
